// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared state encodings, clock constant and defaults for PLL-qualified reset sequencing.
package pll_reset_pkg;

    localparam int unsigned CLK_HZ          = 60_000_000;
    localparam int unsigned HOLD_CYCLES_DEF = 1024;
    localparam int unsigned STAGE_GAP_DEF   = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_SYS_UP    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer with asynchronous active-high clear.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge clr_i) begin
        if (clr_i)
            sync_q <= '0;
        else
            sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged lock-qualified sys/peripheral resets for the PLL clock domain,
// with sticky and counted lock-loss diagnostics.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned STAGE_GAP   = STAGE_GAP_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       clear_lost,
    output logic       sys_reset,
    output logic       periph_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count
);

    localparam int CW = $clog2(max_u(HOLD_CYCLES, STAGE_GAP)) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    logic          lk_s;
    logic          loss;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sys_reset_q, periph_reset_q, ready_q;
    logic          lock_lost_q, lock_lost_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .clr_i (reset),
        .d_i   (locked),
        .q_o   (lk_s)
    );

    // Lock loss takes priority over every count comparison; only SYS_UP/RUN losses are counted.
    always_comb begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
        loss    = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: state_d = lk_s ? ST_HOLD : ST_WAIT_LOCK;
            ST_HOLD: begin
                state_d = !lk_s ? ST_WAIT_LOCK : (cnt_q == HOLD_LAST) ? ST_SYS_UP : ST_HOLD;
                cnt_d   = (lk_s && cnt_q != HOLD_LAST) ? cnt_q + 1'b1 : '0;
            end
            ST_SYS_UP: begin
                loss    = !lk_s;
                state_d = !lk_s ? ST_WAIT_LOCK : (cnt_q == GAP_LAST) ? ST_RUN : ST_SYS_UP;
                cnt_d   = (lk_s && cnt_q != GAP_LAST) ? cnt_q + 1'b1 : '0;
            end
            ST_RUN: begin
                loss    = !lk_s;
                state_d = lk_s ? ST_RUN : ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
        loss_cnt_d  = (loss && loss_cnt_q != 8'hFF) ? loss_cnt_q + 8'd1 : loss_cnt_q;
        lock_lost_d = loss | (lock_lost_q & ~clear_lost);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            sys_reset_q    <= 1'b1;
            periph_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
            loss_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sys_reset_q    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD);
            periph_reset_q <= state_d != ST_RUN;
            ready_q        <= state_d == ST_RUN;
            lock_lost_q    <= lock_lost_d;
            loss_cnt_q     <= loss_cnt_d;
        end
    end

    assign sys_reset       = sys_reset_q;
    assign periph_reset    = periph_reset_q;
    assign ready           = ready_q;
    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = loss_cnt_q;

endmodule
